// File: rtl/axi_stream_if.sv
// rtl/axi_stream_if.sv - byte stream carrying enumerated solution vectors
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/enum_job_scheduler.sv
// rtl/enum_job_scheduler.sv - runs one enumerator per RREF job, reports min popcount and running total
module enum_job_scheduler #(
    parameter  int ROWS    = 2,
    parameter  int COLS    = 3,
    parameter  int TOTAL_W = 32,
    localparam int VARS    = COLS - 1,
    localparam int MIN_W   = $clog2(COLS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [ROWS-1:0][COLS-1:0]  job_rref_i,
    output logic                       enum_start_o,
    output logic [ROWS-1:0][COLS-1:0]  enum_rref_o,
    axi_stream_if.slave                solution_stream,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [MIN_W-1:0]           result_min_o,
    output logic [TOTAL_W-1:0]         total_o,
    output logic [15:0]                jobs_done_o,
    input  logic                       clear_i
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_COLLECT, S_REPORT} state_t;

    localparam int DW = $bits(solution_stream.tdata);

    state_t                      state_q, state_d;
    logic                        job_ready_q, job_ready_d;
    logic                        enum_start_q, enum_start_d;
    logic                        tready_q, tready_d;
    logic                        result_valid_q, result_valid_d;
    logic [MIN_W-1:0]            result_min_q, result_min_d;
    logic [MIN_W-1:0]            min_q, min_d;
    logic [ROWS-1:0][COLS-1:0]   rref_q, rref_d;
    logic [TOTAL_W-1:0]          total_q, total_d;
    logic [15:0]                 jobs_q, jobs_d;

    logic [MIN_W-1:0]            beat_pop;
    logic [MIN_W-1:0]            beat_min;
    logic                        beat_fire;

    // Only the low VARS bits are solution variables; the rest of the byte is padding.
    always_comb begin
        beat_pop = '0;
        for (int i = 0; i < DW; i++) begin
            if (i < VARS && solution_stream.tdata[i]) begin
                beat_pop = beat_pop + MIN_W'(1);
            end
        end
    end

    assign beat_fire = solution_stream.tvalid && tready_q;
    assign beat_min  = (beat_pop < min_q) ? beat_pop : min_q;

    always_comb begin
        state_d        = state_q;
        job_ready_d    = job_ready_q;
        enum_start_d   = enum_start_q;
        tready_d       = tready_q;
        result_valid_d = result_valid_q;
        result_min_d   = result_min_q;
        min_d          = min_q;
        rref_d         = rref_q;
        total_d        = total_q;
        jobs_d         = jobs_q;
        case (state_q)
            S_IDLE: begin
                job_ready_d = 1'b1;
                if (job_valid_i && job_ready_q) begin
                    rref_d       = job_rref_i;
                    min_d        = '1;
                    job_ready_d  = 1'b0;
                    enum_start_d = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                enum_start_d = 1'b0;
                tready_d     = 1'b1;
                state_d      = S_COLLECT;
            end
            S_COLLECT: begin
                if (beat_fire) begin
                    min_d = beat_min;
                    if (solution_stream.tlast) begin
                        result_min_d   = beat_min;
                        result_valid_d = 1'b1;
                        tready_d       = 1'b0;
                        state_d        = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (result_valid_q && result_ready_i) begin
                    result_valid_d = 1'b0;
                    total_d        = total_q + TOTAL_W'(result_min_q);
                    jobs_d         = jobs_q + 16'd1;
                    job_ready_d    = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d        = S_IDLE;
                job_ready_d    = 1'b0;
                enum_start_d   = 1'b0;
                tready_d       = 1'b0;
                result_valid_d = 1'b0;
            end
        endcase
        // A clear coinciding with a result handshake drops that result from the sums.
        if (clear_i) begin
            total_d = '0;
            jobs_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            job_ready_q    <= 1'b0;
            enum_start_q   <= 1'b0;
            tready_q       <= 1'b0;
            result_valid_q <= 1'b0;
            result_min_q   <= '0;
            min_q          <= '1;
            rref_q         <= '0;
            total_q        <= '0;
            jobs_q         <= '0;
        end else begin
            state_q        <= state_d;
            job_ready_q    <= job_ready_d;
            enum_start_q   <= enum_start_d;
            tready_q       <= tready_d;
            result_valid_q <= result_valid_d;
            result_min_q   <= result_min_d;
            min_q          <= min_d;
            rref_q         <= rref_d;
            total_q        <= total_d;
            jobs_q         <= jobs_d;
        end
    end

    assign job_ready_o            = job_ready_q;
    assign enum_start_o           = enum_start_q;
    assign enum_rref_o            = rref_q;
    assign solution_stream.tready = tready_q;
    assign result_valid_o         = result_valid_q;
    assign result_min_o           = result_min_q;
    assign total_o                = total_q;
    assign jobs_done_o            = jobs_q;
endmodule

// File: tb/tb_enum_job_scheduler.sv
// tb/tb_enum_job_scheduler.sv - randomized bench with behavioural enumerator and min/total model
module tb_enum_job_scheduler;
    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int VARS = COLS - 1;

    typedef logic [ROWS-1:0][COLS-1:0] rref_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    rref_t       job_rref;
    logic        enum_start;
    rref_t       enum_rref;
    logic        result_valid;
    logic        result_ready;
    logic [1:0]  result_min;
    logic [31:0] total_o;
    logic [15:0] jobs_done;
    logic        clear;

    axi_stream_if #(.DATA_WIDTH(8)) s_if ();

    enum_job_scheduler #(.ROWS(ROWS), .COLS(COLS), .TOTAL_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .job_valid_i     (job_valid),
        .job_ready_o     (job_ready),
        .job_rref_i      (job_rref),
        .enum_start_o    (enum_start),
        .enum_rref_o     (enum_rref),
        .solution_stream (s_if.slave),
        .result_valid_o  (result_valid),
        .result_ready_i  (result_ready),
        .result_min_o    (result_min),
        .total_o         (total_o),
        .jobs_done_o     (jobs_done),
        .clear_i         (clear)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_bad    = 0;
    int          total_m  = 0;
    int          jobs_m   = 0;
    logic [7:0]  beats[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fewest presses = smallest number of set variable bits over all streamed solutions.
    function automatic int model_min();
        int m = VARS + 1;
        foreach (beats[i]) begin
            int c = $countones(beats[i] & ((8'd1 << VARS) - 8'd1));
            if (c < m) m = c;
        end
        return m;
    endfunction

    task automatic accept_job(input rref_t r, output int to);
        int n = 0;
        to = 0;
        job_rref  = r;
        job_valid = 1'b1;
        while (!job_ready && n < 50) begin
            tick();
            n++;
        end
        if (!job_ready) to = 1;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic stream_job(input int gap, output int to);
        to = 0;
        for (int i = 0; i < beats.size(); i++) begin
            int n = 0;
            for (int g = 0; g < gap; g++) tick();
            s_if.tvalid = 1'b1;
            s_if.tdata  = beats[i];
            s_if.tlast  = (i == beats.size() - 1);
            while (!s_if.tready && n < 50) begin
                tick();
                n++;
            end
            if (!s_if.tready) to = 1;
            tick();
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
            s_if.tdata  = 8'hxx;
        end
    endtask

    task automatic run_job(input rref_t r, input int gap, input int hold, input logic clr_hs,
                           output int to, output logic [1:0] got_min,
                           output logic start_ok, output logic report_ok);
        int to1, to2;
        accept_job(r, to1);
        start_ok = (enum_start === 1'b1) && (job_ready === 1'b0) && (enum_rref === r) && (s_if.tready === 1'b0);
        tick();
        start_ok = start_ok && (enum_start === 1'b0);
        stream_job(gap, to2);
        report_ok = (result_valid === 1'b1) && (s_if.tready === 1'b0);
        got_min = result_min;
        for (int h = 0; h < hold; h++) begin
            tick();
            report_ok = report_ok && (result_min === got_min) && (result_valid === 1'b1)
                        && (s_if.tready === 1'b0) && (job_ready === 1'b0);
        end
        result_ready = 1'b1;
        clear        = clr_hs;
        tick();
        result_ready = 1'b0;
        clear        = 1'b0;
        report_ok = report_ok && (job_ready === 1'b1) && (result_valid === 1'b0);
        to = to1 | to2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({job_ready, enum_start, s_if.tready, result_valid} !== 4'b0 || result_min !== 2'd0
            || total_o !== 32'd0 || jobs_done !== 16'd0 || enum_rref !== rref_t'(0)) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b start=%b tready=%b rv=%b min=%0d total=%0d jobs=%0d rref=%h, required all zero",
                     job_ready, enum_start, s_if.tready, result_valid, result_min, total_o, jobs_done, enum_rref);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (job_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_ready: job_ready=%b required 1", job_ready);
        end
    endtask

    task automatic check_job(input string name, input int to, input logic [1:0] got, input int exp_min,
                             input logic start_ok, input logic report_ok);
        n_checks++;
        if (to != 0) begin n_bad++; $display("FAIL %s_timeout: handshake bound expired", name); end
        n_checks++;
        if (!start_ok) begin n_bad++; $display("FAIL %s_start: enum_start/rref/ready not as required", name); end
        n_checks++;
        if (!report_ok) begin n_bad++; $display("FAIL %s_report: result not held/tready not low", name); end
        n_checks++;
        if (got !== 2'(exp_min)) begin n_bad++; $display("FAIL %s_min: got %0d required %0d", name, got, exp_min); end
        n_checks++;
        if (total_o !== 32'(total_m) || jobs_done !== 16'(jobs_m)) begin
            n_bad++;
            $display("FAIL %s_total: total=%0d jobs=%0d required %0d %0d", name, total_o, jobs_done, total_m, jobs_m);
        end
    endtask

    task automatic test_basic();
        int to; logic [1:0] got; logic s_ok, r_ok; int e;
        beats = '{8'h03, 8'h01};
        e = model_min();
        run_job({3'b101, 3'b011}, 0, 0, 1'b0, to, got, s_ok, r_ok);
        total_m += e; jobs_m++;
        check_job("basic", to, got, e, s_ok, r_ok);
        n_checks++;
        if (got !== 2'd1 || total_o !== 32'd1 || jobs_done !== 16'd1) begin
            n_bad++;
            $display("FAIL basic_const: min=%0d total=%0d jobs=%0d required 1 1 1", got, total_o, jobs_done);
        end
    endtask

    task automatic test_back_to_back();
        int to; logic [1:0] got; logic s_ok, r_ok; int e;
        beats = '{8'h03};
        e = model_min();
        run_job({3'b011, 3'b110}, 0, 0, 1'b0, to, got, s_ok, r_ok);
        total_m += e; jobs_m++;
        check_job("b2b_a", to, got, e, s_ok, r_ok);
        beats = '{8'h02, 8'h01};
        e = model_min();
        run_job({3'b100, 3'b001}, 0, 1, 1'b0, to, got, s_ok, r_ok);
        total_m += e; jobs_m++;
        check_job("b2b_b", to, got, e, s_ok, r_ok);
    endtask

    task automatic test_mask();
        int to; logic [1:0] got; logic s_ok, r_ok; int e;
        beats = '{8'hFD};
        e = model_min();
        run_job({3'b111, 3'b010}, 0, 0, 1'b0, to, got, s_ok, r_ok);
        total_m += e; jobs_m++;
        check_job("mask", to, got, e, s_ok, r_ok);
    endtask

    task automatic test_gaps();
        int to; logic [1:0] got; logic s_ok, r_ok; int e;
        beats = '{8'h03, 8'h02, 8'h03};
        e = model_min();
        run_job({3'b001, 3'b101}, 5, 10, 1'b0, to, got, s_ok, r_ok);
        total_m += e; jobs_m++;
        check_job("gaps", to, got, e, s_ok, r_ok);
    endtask

    task automatic test_clear();
        int to; logic [1:0] got; logic s_ok, r_ok; int e;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total_m = 0; jobs_m = 0;
        for (int j = 0; j < 4; j++) begin
            if (j < 3) beats = '{8'h03}; else beats = '{8'h01};
            e = model_min();
            run_job(rref_t'(j + 1), 0, 0, 1'b0, to, got, s_ok, r_ok);
            total_m += e; jobs_m++;
        end
        n_checks++;
        if (total_o !== 32'd7 || jobs_done !== 16'd4) begin
            n_bad++;
            $display("FAIL clear_setup: total=%0d jobs=%0d required 7 4", total_o, jobs_done);
        end
        beats = '{8'h03};
        e = model_min();
        run_job({3'b110, 3'b011}, 0, 2, 1'b1, to, got, s_ok, r_ok);
        total_m = 0; jobs_m = 0;
        check_job("clear_hs", to, got, e, s_ok, r_ok);
    endtask

    task automatic test_reset_mid();
        int to; logic [1:0] got; logic s_ok, r_ok; int e;
        accept_job({3'b011, 3'b011}, to);
        tick();
        s_if.tvalid = 1'b1; s_if.tdata = 8'h00; s_if.tlast = 1'b0;
        tick();
        s_if.tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({job_ready, enum_start, s_if.tready, result_valid} !== 4'b0 || result_min !== 2'd0
            || total_o !== 32'd0 || jobs_done !== 16'd0 || enum_rref !== rref_t'(0)) begin
            n_bad++;
            $display("FAIL midreset_outputs: ready=%b start=%b tready=%b rv=%b min=%0d total=%0d jobs=%0d, required zero",
                     job_ready, enum_start, s_if.tready, result_valid, result_min, total_o, jobs_done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total_m = 0; jobs_m = 0;
        beats = '{8'h03, 8'h02};
        e = model_min();
        run_job({3'b101, 3'b010}, 0, 0, 1'b0, to, got, s_ok, r_ok);
        total_m += e; jobs_m++;
        check_job("after_reset", to, got, e, s_ok, r_ok);
    endtask

    task automatic test_random();
        int to; logic [1:0] got; logic s_ok, r_ok; int e;
        for (int j = 0; j < 20; j++) begin
            int nb = $urandom_range(1, 4);
            beats = {};
            for (int b = 0; b < nb; b++) beats.push_back(8'($urandom));
            e = model_min();
            run_job(rref_t'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, to, got, s_ok, r_ok);
            total_m += e; jobs_m++;
            check_job("random", to, got, e, s_ok, r_ok);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        job_valid    = 1'b0;
        job_rref     = '0;
        result_ready = 1'b0;
        clear        = 1'b0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = 8'h00;
        s_if.tlast   = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_mask();
        test_gaps();
        test_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
